// File: rtl/resp_cap_pkg.sv
// Shared types and the MISR update for response_capture.
// The bench model calls the same misr_next as the RTL.
package resp_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int          MISR_MAX_W  = 64;
    localparam logic [15:0] DEF_POLY    = 16'h1021;
    localparam logic [15:0] DEF_SEED    = 16'h0000;
    localparam logic [15:0] DEF_EXP_SIG = 16'h0003;

    // Generic-width MISR step; w is the active width (3..64), upper bits are masked off.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic                  c,
        input logic                  d,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic [5:0]            msb_idx;
        msb_idx = 6'(w - 32'd1);
        if (w >= 32'd64) begin
            mask = {MISR_MAX_W{1'b1}};
        end else begin
            mask = (64'd1 << w) - 64'd1;
        end
        nxt = (sig << 1) ^ {62'd0, d, c};
        if (sig[msb_idx]) begin
            nxt = nxt ^ poly;
        end else begin
            nxt = nxt;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/resp_misr.sv
// Signature register for response_capture: loads SEED, then folds {d,c} in each enabled cycle.
module resp_misr
    import resp_cap_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_c,
    input  logic             i_d,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_sig_next
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    assign w_sig_next = SIG_W'(misr_next(MISR_MAX_W'(r_sig), i_c, i_d,
                                         MISR_MAX_W'(POLY), SIG_W));

    // Signature register: load wins over enable so a restart never folds a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= w_sig_next;
        end else begin
            r_sig <= r_sig;
        end
    end

    assign o_sig      = r_sig;
    assign o_sig_next = w_sig_next;

endmodule

// File: rtl/response_capture.sv
// Capture end for DUT outputs c/d: MISR signature, per-signal toggle counts and a
// registered pass/fail verdict after a fixed window of NUM_CYCLES samples.
module response_capture
    import resp_cap_pkg::*;
#(
    parameter int               NUM_CYCLES = 4,
    parameter int               CNT_W      = 8,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = 16'h1021,
    parameter logic [SIG_W-1:0] SEED       = 16'h0000,
    parameter logic [SIG_W-1:0] EXP_SIG    = 16'h0003
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] c_toggles,
    output logic [CNT_W-1:0] d_toggles
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_load;
    logic             w_en;
    logic             w_last;
    logic [SIG_W-1:0] w_sig;
    logic [SIG_W-1:0] w_sig_next;

    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_c_tog;
    logic [CNT_W-1:0] r_d_tog;
    logic             r_prev_c;
    logic             r_prev_d;

    resp_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_c        (c),
        .i_d        (d),
        .o_sig      (w_sig),
        .o_sig_next (w_sig_next)
    );

    // Next-state and per-cycle strobes; start is only honoured outside CAPTURE.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_CAPTURE;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_CAPTURE: begin
                w_en = 1'b1;
                if (r_cycle_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, reference samples and the verdict; all hold outside load/capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cycle_cnt <= CNT_ZERO;
            r_c_tog     <= CNT_ZERO;
            r_d_tog     <= CNT_ZERO;
            r_prev_c    <= 1'b0;
            r_prev_d    <= 1'b0;
        end else if (w_load) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cycle_cnt <= CNT_ZERO;
            r_c_tog     <= CNT_ZERO;
            r_d_tog     <= CNT_ZERO;
            r_prev_c    <= c;
            r_prev_d    <= d;
        end else if (w_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            r_prev_c    <= c;
            r_prev_d    <= d;
            if ((c != r_prev_c) && (r_c_tog != CNT_MAX)) begin
                r_c_tog <= r_c_tog + CNT_ONE;
            end
            if ((d != r_prev_d) && (r_d_tog != CNT_MAX)) begin
                r_d_tog <= r_d_tog + CNT_ONE;
            end
            // The verdict uses the signature being written on this final edge.
            if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_sig_next == EXP_SIG);
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_sig;
    assign cycle_cnt = r_cycle_cnt;
    assign c_toggles = r_c_tog;
    assign d_toggles = r_d_tog;

endmodule

// File: tb/tb_response_capture.sv
// Scoreboard bench for response_capture: default instance (a) and a small
// instance (b) with SEED=0x8000, CNT_W=2, NUM_CYCLES=3.
module tb_response_capture;
    import resp_cap_pkg::*;

    typedef struct packed {
        logic [15:0] sig;
        logic [7:0]  cyc;
        logic [7:0]  ct;
        logic [7:0]  dt;
        logic        pass;
    } exp_t;

    typedef logic [15:0] sv4_t [4];
    typedef logic [15:0] sv3_t [3];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, c_a, d_a, busy_a, done_a, pass_a;
    logic [15:0] sig_a;
    logic [7:0]  cyc_a, ct_a, dt_a;
    logic        start_b, c_b, d_b, busy_b, done_b, pass_b;
    logic [15:0] sig_b;
    logic [1:0]  cyc_b, ct_b, dt_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    logic pd_a = 1'b0;
    logic pd_b = 1'b0;
    int   errors = 0;
    int   checks = 0;

    response_capture u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .c(c_a), .d(d_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
        .cycle_cnt(cyc_a), .c_toggles(ct_a), .d_toggles(dt_a)
    );

    response_capture #(.NUM_CYCLES(3), .CNT_W(2), .SEED(16'h8000)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .c(c_b), .d(d_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
        .cycle_cnt(cyc_b), .c_toggles(ct_b), .d_toggles(dt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the expected verdict and compare it.
    always @(negedge clk) begin
        if (done_a && !pd_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_signature", sig_a, e_a.sig);
                chk("a_cycle_cnt", cyc_a, e_a.cyc);
                chk("a_c_toggles", ct_a, e_a.ct);
                chk("a_d_toggles", dt_a, e_a.dt);
                chk("a_pass", pass_a, e_a.pass);
            end
        end
        if (done_b && !pd_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_signature", sig_b, e_b.sig);
                chk("b_cycle_cnt", cyc_b, e_b.cyc);
                chk("b_c_toggles", ct_b, e_b.ct);
                chk("b_d_toggles", dt_b, e_b.dt);
                chk("b_pass", pass_b, e_b.pass);
            end
        end
        if (!done_a) chk("a_pass_without_done", pass_a, 64'd0);
        if (!done_b) chk("b_pass_without_done", pass_b, 64'd0);
        pd_a <= done_a;
        pd_b <= done_b;
    end

    task automatic run_a(input logic c0, input logic d0, input logic [3:0] cv,
                         input logic [3:0] dv, input logic hold, input sv4_t sv,
                         input exp_t e);
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b1; c_a = c0; d_a = d0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a_busy_capture", busy_a, 64'd1);
            if (i == 0) begin
                chk("a_cnt_cleared", cyc_a, 64'd0);
                chk("a_done_cleared", done_a, 64'd0);
                chk("a_ctog_cleared", ct_a, 64'd0);
            end else begin
                chk("a_sig_step", sig_a, sv[i-1]);
            end
            start_a = hold; c_a = cv[i]; d_a = dv[i];
        end
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy_after", busy_a, 64'd0);
        chk("a_sig_last", sig_a, sv[3]);
    endtask

    task automatic run_b(input logic c0, input logic d0, input logic [2:0] cv,
                         input logic [2:0] dv, input sv3_t sv, input exp_t e);
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b1; c_b = c0; d_b = d0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_busy_capture", busy_b, 64'd1);
            if (i > 0) chk("b_sig_step", sig_b, sv[i-1]);
            start_b = 1'b0; c_b = cv[i]; d_b = dv[i];
        end
        @(negedge clk);
        chk("b_busy_after", busy_b, 64'd0);
        chk("b_sig_last", sig_b, sv[2]);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; c_a = 1'b0; d_a = 1'b0;
        start_b = 1'b0; c_b = 1'b0; d_b = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_a, 64'd0);
        chk("rst_done", done_a, 64'd0);
        chk("rst_sig_a", sig_a, 64'h0000);
        chk("rst_sig_b", sig_b, 64'h8000);
        chk("rst_cnt", cyc_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // c = 0,1,0,1 ; d = 0,0,1,1 -> 0x0003, pass
        run_a(1'b0, 1'b0, 4'b1010, 4'b1100, 1'b0,
              sv4_t'{16'h0000, 16'h0001, 16'h0000, 16'h0003},
              exp_t'{sig: 16'h0003, cyc: 8'd4, ct: 8'd3, dt: 8'd1, pass: 1'b1});
        repeat (3) @(negedge clk);
        chk("a_done_holds", done_a, 64'd1);
        chk("a_sig_holds", sig_a, 64'h0003);
        chk("a_pass_holds", pass_a, 64'd1);

        // Restart from DONE with a single pulse on c -> 1,2,4,8, fail
        run_a(1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0,
              sv4_t'{16'h0001, 16'h0002, 16'h0004, 16'h0008},
              exp_t'{sig: 16'h0008, cyc: 8'd4, ct: 8'd2, dt: 8'd0, pass: 1'b0});

        // start held through CAPTURE; c = 0,1,0,1 ; d = 1,0,1,0 from (1,0)
        run_a(1'b1, 1'b0, 4'b1010, 4'b0101, 1'b1,
              sv4_t'{16'h0002, 16'h0005, 16'h0008, 16'h0011},
              exp_t'{sig: 16'h0011, cyc: 8'd4, ct: 8'd4, dt: 8'd4, pass: 1'b0});

        // Abort a run with reset after T2
        @(negedge clk);
        start_a = 1'b1; c_a = 1'b0; d_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0; c_a = 1'b1; d_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_cnt_before", cyc_a, 64'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 64'd0);
        chk("abort_done", done_a, 64'd0);
        chk("abort_pass", pass_a, 64'd0);
        chk("abort_sig", sig_a, 64'h0000);
        chk("abort_cnt", cyc_a, 64'd0);
        chk("abort_ctog", ct_a, 64'd0);
        chk("abort_dtog", dt_a, 64'd0);
        chk("abort_sig_b", sig_b, 64'h8000);
        @(negedge clk);
        rst_n = 1'b1; c_a = 1'b0; d_a = 1'b0;
        run_a(1'b0, 1'b0, 4'b1010, 4'b1100, 1'b0,
              sv4_t'{16'h0000, 16'h0001, 16'h0000, 16'h0003},
              exp_t'{sig: 16'h0003, cyc: 8'd4, ct: 8'd3, dt: 8'd1, pass: 1'b1});

        // Feedback from SEED=0x8000 with zero inputs
        run_b(1'b0, 1'b0, 3'b000, 3'b000,
              sv3_t'{16'h1021, 16'h2042, 16'h4084},
              exp_t'{sig: 16'h4084, cyc: 8'd3, ct: 8'd0, dt: 8'd0, pass: 1'b0});
        // c toggles every sample -> c_toggles reaches 3 (the 2-bit maximum)
        run_b(1'b0, 1'b0, 3'b101, 3'b000,
              sv3_t'{16'h1020, 16'h2040, 16'h4081},
              exp_t'{sig: 16'h4081, cyc: 8'd3, ct: 8'd3, dt: 8'd0, pass: 1'b0});
        // d toggles every sample
        run_b(1'b0, 1'b0, 3'b000, 3'b101,
              sv3_t'{16'h1023, 16'h2046, 16'h408E},
              exp_t'{sig: 16'h408E, cyc: 8'd3, ct: 8'd0, dt: 8'd3, pass: 1'b0});

        repeat (3) @(negedge clk);
        chk("a_verdicts_drained", 64'(q_a.size()), 64'd0);
        chk("b_verdicts_drained", 64'(q_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
